// File: rtl/tea_decryptor.sv
// TEA block decryptor: 32 rounds, one per cycle, 64-bit block, 128-bit key, constant-time.
// Output valid rises NUM_ROUNDS+1 cycles after accept and holds with stable data until the downstream ready handshake.
module tea_decryptor #(
    parameter logic [31:0] DELTA      = 32'h9E3779B9,
    parameter int          NUM_ROUNDS = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [127:0] i_key,
    input  logic         i_axis_valid_s,
    output logic         o_axis_ready_s,
    input  logic [63:0]  i_axis_data_s,
    output logic         o_axis_valid_m,
    input  logic         i_axis_ready_m,
    output logic [63:0]  o_axis_data_m
);

    localparam int          CW       = $clog2(NUM_ROUNDS);
    localparam logic [CW-1:0] LAST   = CW'(NUM_ROUNDS - 1);
    localparam logic [31:0] SUM_INIT = 32'(DELTA * 32'(NUM_ROUNDS));

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        LOADING    = 2'b01,
        PROCESSING = 2'b10,
        DONE       = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     sum_q, sum_d;
    logic [31:0]     v0_q, v0_d;
    logic [31:0]     v1_q, v1_d;
    logic [127:0]    key_q, key_d;

    logic [31:0]     k0, k1, k2, k3;
    logic [31:0]     v1_nx, v0_nx;

    assign k0 = key_q[127:96];
    assign k1 = key_q[95:64];
    assign k2 = key_q[63:32];
    assign k3 = key_q[31:0];

    // v0 is recovered from the already-updated v1, mirroring the encrypt order in reverse.
    assign v1_nx = v1_q - (((v0_q << 4) + k2) ^ (v0_q + sum_q) ^ ((v0_q >> 5) + k3));
    assign v0_nx = v0_q - (((v1_nx << 4) + k0) ^ (v1_nx + sum_q) ^ ((v1_nx >> 5) + k1));

    assign o_axis_ready_s = (state_q == IDLE) && !i_rst;
    assign o_axis_valid_m = (state_q == DONE);
    assign o_axis_data_m  = {v0_q, v1_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        key_d   = key_q;
        case (state_q)
            IDLE: begin
                if (i_axis_valid_s && o_axis_ready_s) begin
                    v0_d    = i_axis_data_s[63:32];
                    v1_d    = i_axis_data_s[31:0];
                    key_d   = i_key;
                    state_d = LOADING;
                end
            end
            LOADING: begin
                sum_d   = SUM_INIT;
                cnt_d   = '0;
                state_d = PROCESSING;
            end
            PROCESSING: begin
                v0_d  = v0_nx;
                v1_d  = v1_nx;
                sum_d = sum_q - DELTA;
                // Counter parks at LAST so it never wraps.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (i_axis_ready_m) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            v0_q    <= '0;
            v1_q    <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            key_q   <= key_d;
        end
    end

endmodule

// File: tb/tb_tea_decryptor.sv
// Bench for tea_decryptor: directed steps with a plaintext scoreboard and an independent TEA encrypt model.
module tb_tea_decryptor;

    logic         i_clk;
    logic         i_rst;
    logic [127:0] i_key;
    logic         i_axis_valid_s;
    logic         o_axis_ready_s;
    logic [63:0]  i_axis_data_s;
    logic         o_axis_valid_m;
    logic         i_axis_ready_m;
    logic [63:0]  o_axis_data_m;

    tea_decryptor dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_key          (i_key),
        .i_axis_valid_s (i_axis_valid_s),
        .o_axis_ready_s (o_axis_ready_s),
        .i_axis_data_s  (i_axis_data_s),
        .o_axis_valid_m (o_axis_valid_m),
        .i_axis_ready_m (i_axis_ready_m),
        .o_axis_data_m  (o_axis_data_m)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          checks;
    int          errors;
    int          cyc;
    logic [63:0] sb[$];

    function automatic logic [63:0] tea_enc(input logic [63:0] pt, input logic [127:0] key);
        logic [31:0] v0, v1, sum;
        logic [31:0] k0, k1, k2, k3;
        v0 = pt[63:32];
        v1 = pt[31:0];
        k0 = key[127:96];
        k1 = key[95:64];
        k2 = key[63:32];
        k3 = key[31:0];
        sum = 32'h0;
        for (int r = 0; r < 32; r++) begin
            sum = sum + 32'h9E3779B9;
            v0  = v0 + (((v1 << 4) + k0) ^ (v1 + sum) ^ ((v1 >> 5) + k1));
            v1  = v1 + (((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
        end
        return {v0, v1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    // Presents a block and returns the cycle index of the accepting edge.
    task automatic do_accept(input logic [63:0] ct, input logic [127:0] key, output int acc_cyc);
        bit done;
        done = 1'b0;
        acc_cyc = -1;
        i_axis_data_s  = ct;
        i_key          = key;
        i_axis_valid_s = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            if (o_axis_ready_s) begin
                done = 1'b1;
                tick();
                acc_cyc = cyc;
            end else begin
                tick();
            end
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_axis_valid_m && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_block(input string tag, input logic [63:0] pt, input logic [127:0] key);
        int acc, lat;
        sb.push_back(pt);
        do_accept(tea_enc(pt, key), key, acc);
        i_axis_valid_s = 1'b0;
        wait_valid(lat);
        chk({tag, "_latency"}, 64'(lat), 64'd33);
        chk({tag, "_data"}, o_axis_data_m, sb.pop_front());
        tick();
        chk({tag, "_pulse"}, 64'(o_axis_valid_m), 64'd0);
    endtask

    initial begin
        int          acc1, acc2, lat;
        bit          busy_bad, hold_bad, seen_out;
        logic [63:0] held, pt_a, pt_b;
        logic [127:0] key_a, key_b;

        checks = 0;
        errors = 0;
        cyc    = 0;
        i_rst          = 1'b1;
        i_key          = '0;
        i_axis_valid_s = 1'b0;
        i_axis_data_s  = '0;
        i_axis_ready_m = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_ready", 64'(o_axis_ready_s), 64'd0);
        chk("rst_valid", 64'(o_axis_valid_m), 64'd0);
        chk("rst_data", o_axis_data_m, 64'd0);
        i_rst = 1'b0;
        #1;
        chk("idle_ready", 64'(o_axis_ready_s), 64'd1);

        // Known vector: all-zero key and plaintext
        sb.push_back(64'h0);
        do_accept(64'h41EA3A0A_94BAA940, 128'h0, acc1);
        i_axis_valid_s = 1'b0;
        wait_valid(lat);
        chk("kv_latency", 64'(lat), 64'd33);
        chk("kv_data", o_axis_data_m, sb.pop_front());
        tick();
        chk("kv_pulse", 64'(o_axis_valid_m), 64'd0);

        // Backpressure: 10 cycles held, handshake on the 11th
        pt_a  = 64'h01234567_89ABCDEF;
        key_a = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        i_axis_ready_m = 1'b0;
        sb.push_back(pt_a);
        do_accept(tea_enc(pt_a, key_a), key_a, acc1);
        i_axis_valid_s = 1'b0;
        wait_valid(lat);
        chk("bp_latency", 64'(lat), 64'd33);
        held = o_axis_data_m;
        hold_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!o_axis_valid_m || o_axis_data_m !== held || o_axis_ready_s) hold_bad = 1'b1;
        end
        chk("bp_hold", 64'(hold_bad), 64'd0);
        chk("bp_data", o_axis_data_m, sb.pop_front());
        i_axis_ready_m = 1'b1;
        tick();
        chk("bp_release_valid", 64'(o_axis_valid_m), 64'd0);
        chk("bp_release_ready", 64'(o_axis_ready_s), 64'd1);

        // Busy isolation: valid stays high, data and key churn every cycle
        pt_a  = 64'hDEADBEEF_CAFEF00D;
        key_a = 128'hA5A5A5A5_5A5A5A5A_12345678_9ABCDEF0;
        pt_b  = 64'h0BADC0DE_FEEDFACE;
        key_b = 128'h0F0F0F0F_F0F0F0F0_13579BDF_2468ACE0;
        sb.push_back(pt_a);
        do_accept(tea_enc(pt_a, key_a), key_a, acc1);
        busy_bad = 1'b0;
        lat = 0;
        while (!o_axis_valid_m && lat < 60) begin
            if (o_axis_ready_s) busy_bad = 1'b1;
            i_axis_data_s = {$urandom, $urandom};
            i_key         = {$urandom, $urandom, $urandom, $urandom};
            tick();
            lat++;
        end
        chk("busy_ready_low", 64'(busy_bad), 64'd0);
        chk("busy_latency", 64'(lat), 64'd33);
        chk("busy_data", o_axis_data_m, sb.pop_front());
        chk("busy_done_ready", 64'(o_axis_ready_s), 64'd0);
        sb.push_back(pt_b);
        i_axis_data_s = tea_enc(pt_b, key_b);
        i_key         = key_b;
        tick();
        do_accept(tea_enc(pt_b, key_b), key_b, acc2);
        i_axis_valid_s = 1'b0;
        chk("busy_second_gap", 64'(acc2 - acc1), 64'd35);
        wait_valid(lat);
        chk("busy_second_latency", 64'(lat), 64'd33);
        chk("busy_second_data", o_axis_data_m, sb.pop_front());
        tick();

        // Reset mid-operation, around round 17
        pt_a  = 64'h11111111_22222222;
        key_a = 128'h33333333_44444444_55555555_66666666;
        sb.push_back(pt_a);
        do_accept(tea_enc(pt_a, key_a), key_a, acc1);
        i_axis_valid_s = 1'b0;
        for (int i = 0; i < 18; i++) tick();
        i_rst = 1'b1;
        tick();
        void'(sb.pop_front());
        chk("mid_rst_ready", 64'(o_axis_ready_s), 64'd0);
        chk("mid_rst_valid", 64'(o_axis_valid_m), 64'd0);
        chk("mid_rst_data", o_axis_data_m, 64'd0);
        i_rst = 1'b0;
        #1;
        chk("mid_rst_idle", 64'(o_axis_ready_s), 64'd1);
        seen_out = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_axis_valid_m) seen_out = 1'b1;
        end
        chk("mid_rst_no_output", 64'(seen_out), 64'd0);
        run_block("post_rst", 64'h76543210_FEDCBA98, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000);

        // Back-to-back with valid held permanently high
        pt_a  = 64'hAAAAAAAA_55555555;
        key_a = 128'h01020304_05060708_090A0B0C_0D0E0F10;
        pt_b  = 64'h12481248_84218421;
        key_b = 128'hFEDCBA98_76543210_01234567_89ABCDEF;
        sb.push_back(pt_a);
        do_accept(tea_enc(pt_a, key_a), key_a, acc1);
        wait_valid(lat);
        chk("b2b_a_latency", 64'(lat), 64'd33);
        chk("b2b_a_data", o_axis_data_m, sb.pop_front());
        sb.push_back(pt_b);
        tick();
        do_accept(tea_enc(pt_b, key_b), key_b, acc2);
        chk("b2b_gap", 64'(acc2 - acc1), 64'd35);
        i_axis_valid_s = 1'b0;
        wait_valid(lat);
        chk("b2b_b_latency", 64'(lat), 64'd33);
        chk("b2b_b_data", o_axis_data_m, sb.pop_front());
        tick();

        // Random round-trip pairs
        for (int n = 0; n < 200; n++) begin
            run_block("rt", {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        end

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tea_decryptor.md
Name: tea_decryptor

Overview:
- Inverse of the team's TEA encrypt accelerator; the receive-side block of the crypto datapath.
- Accepts one 64-bit ciphertext block on an AXI-Stream-style slave port and decrypts it with a 128-bit key using 32 TEA decryption rounds, one round per cycle.
- Presents the 64-bit plaintext on an AXI-Stream-style master port.
- Control flow is constant-time: latency and state sequence never depend on key or data.

Parameters:
- DELTA, 32'h9E3779B9, TEA key-schedule constant.
- NUM_ROUNDS, 32, round count. The counter is $clog2(NUM_ROUNDS) bits wide. The initial sum is (DELTA*NUM_ROUNDS) mod 2^32, which is 32'hC6EF3720 at the defaults.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, synchronous, active-high
- i_key  input  128  key; k0=[127:96], k1=[95:64], k2=[63:32], k3=[31:0]
- i_axis_valid_s  input  1  ciphertext valid
- o_axis_ready_s  output  1  ready to accept ciphertext
- i_axis_data_s  input  64  ciphertext; v0=[63:32], v1=[31:0]
- o_axis_valid_m  output  1  plaintext valid
- i_axis_ready_m  input  1  downstream ready
- o_axis_data_m  output  64  plaintext {v0,v1}

Behaviour:
- Reset (i_rst high at an edge):
  - state=IDLE, round counter=0, sum=0, data and key registers=0.
  - o_axis_valid_m=0, o_axis_data_m=0.
  - o_axis_ready_s=0 while i_rst is high.
  - Reset overrides every state, including mid-PROCESSING and DONE. Any in-flight block is discarded with no output.
- Outputs:
  - o_axis_ready_s = (state==IDLE) && !i_rst.
  - o_axis_valid_m = (state==DONE).
  - o_axis_data_m is driven from registers only (no combinational path from inputs).
- FSM, 2-bit: IDLE=00, LOADING=01, PROCESSING=10, DONE=11.
  - IDLE: if i_axis_valid_s && o_axis_ready_s, capture i_axis_data_s into v0/v1 and i_key into the key register, then go to LOADING. Otherwise stay.
  - LOADING: sum <= DELTA*NUM_ROUNDS, counter <= 0. Go to PROCESSING unconditionally.
  - PROCESSING: perform one round per edge and increment the counter. When the counter == NUM_ROUNDS-1, the round executes on that edge and the next state is DONE. Otherwise stay. Exactly NUM_ROUNDS rounds are performed.
  - DONE: output valid. If o_axis_valid_m && i_axis_ready_m, go to IDLE. Otherwise hold, with o_axis_data_m stable.
- Round (all arithmetic mod 2^32, logical shifts):
  - v1' = v1 - (((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3))
  - v0' = v0 - (((v1'<<4)+k0) ^ (v1'+sum) ^ ((v1'>>5)+k1)), using the updated v1'.
  - sum' = sum - DELTA.
  - After the final round, sum == 0.
- Latency: o_axis_valid_m rises exactly NUM_ROUNDS+1 cycles (33 at defaults) after the input-accepting edge, independent of key and data.
- Single block in flight. o_axis_ready_s stays low from the accept edge until DONE completes its handshake. The earliest next accept is the cycle after the output handshake (no same-cycle accept in DONE).
- Key and data isolation:
  - i_key and i_axis_data_s are ignored outside the IDLE handshake.
  - Changes to them mid-operation have no effect.
  - i_axis_valid_s held high during a busy period is not accepted until IDLE.
- Next-state logic must depend only on state, counter, and handshake signals; never on key or data.
- Counter: never exceeds NUM_ROUNDS-1 and does not wrap.

Test Plan:
- Known vector:
  - Stimulus: key=0, ciphertext=64'h41EA3A0A_94BAA940, i_axis_ready_m=1.
  - Response: o_axis_data_m=64'h0, valid exactly 33 cycles after accept, single-cycle valid pulse.
- Round-trip:
  - Stimulus: 200 random key/plaintext pairs encrypted by the team's TEA encryptor model, then fed to the decryptor.
  - Response: output equals the original plaintext, with latency 33 for every pair (constant-time check).
- Backpressure:
  - Stimulus: hold i_axis_ready_m=0 for 10 cycles after valid rises.
  - Response: o_axis_valid_m stays 1 and o_axis_data_m is unchanged all 10 cycles. Handshake on cycle 11, then IDLE and o_axis_ready_s=1 on the next cycle.
- Busy isolation:
  - Stimulus: keep i_axis_valid_s=1 with changing data and change i_key every cycle during PROCESSING.
  - Response: o_axis_ready_s=0 throughout, the result matches the originally captured block/key, and the second block is accepted only after the output handshake.
- Reset mid-operation:
  - Stimulus: assert i_rst for 1 cycle at round 17.
  - Response: state=IDLE, o_axis_valid_m=0, o_axis_data_m=0, no output emitted. A new block afterward decrypts correctly with latency 33.
- Back-to-back:
  - Stimulus: two blocks, with i_axis_ready_m=1 and i_axis_valid_s permanently high.
  - Response: accept edges exactly 35 cycles apart (33 + DONE + IDLE), both plaintexts correct.
